// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: per-bay occupancy, lot count/full status
// and a timed entry gate driven from edge-detected bay/entry sensors.
module parking_lot_ctrl #(
   parameter int NUM_SLOTS        = 4,
   parameter int GATE_OPEN_CYCLES = 8,
   localparam int CW              = $clog2(NUM_SLOTS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sense_entry,
   input  logic [NUM_SLOTS-1:0] sense_exit,
   output logic [NUM_SLOTS-1:0] gled,
   output logic [NUM_SLOTS-1:0] rled,
   output logic [CW-1:0]        occ_count,
   output logic                 full,
   output logic                 gate_open,
   output logic                 entry_rejected
);

   typedef enum logic {IDLE, OPEN} gate_e;

   gate_e                state_q, state_d;
   logic [15:0]          timer_q, timer_d;
   logic                 entry_q;
   logic [NUM_SLOTS-1:0] exit_q;
   logic [NUM_SLOTS-1:0] occ_q, occ_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 full_q, full_d;
   logic                 rej_q, rej_d;

   logic                 entry_evt;
   logic [NUM_SLOTS-1:0] exit_evt;
   logic [NUM_SLOTS-1:0] clr;
   logic [NUM_SLOTS-1:0] free;
   logic [NUM_SLOTS-1:0] alloc;
   logic [CW-1:0]        nclr;
   logic                 admit;

   assign entry_evt = sense_entry & ~entry_q;
   assign exit_evt  = sense_exit & ~exit_q;
   assign clr       = exit_evt & occ_q;
   assign free      = ~occ_q;
   // Isolate lowest free bay of the pre-cycle map; same-cycle exits excluded
   assign alloc     = free & (~free + NUM_SLOTS'(1));
   assign admit     = entry_evt & (state_q == IDLE) & ~(&occ_q);

   always_comb begin
      nclr = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         nclr = nclr + CW'(clr[i]);
      end
   end

   always_comb begin
      occ_d   = (occ_q & ~clr) | (admit ? alloc : '0);
      cnt_d   = cnt_q + CW'(admit) - nclr;
      full_d  = (cnt_d == CW'(NUM_SLOTS));
      rej_d   = entry_evt & ~admit;
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE: begin
            if (admit) begin
               state_d = OPEN;
               timer_d = 16'(GATE_OPEN_CYCLES - 1);
            end
         end
         OPEN: begin
            if (timer_q == 16'd0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // Capture live levels so a sensor held through reset gives no event
         entry_q <= sense_entry;
         exit_q  <= sense_exit;
         occ_q   <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         rej_q   <= 1'b0;
         state_q <= IDLE;
         timer_q <= 16'd0;
      end else begin
         entry_q <= sense_entry;
         exit_q  <= sense_exit;
         occ_q   <= occ_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         rej_q   <= rej_d;
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   assign gled           = ~occ_q;
   assign rled           = occ_q;
   assign occ_count      = cnt_q;
   assign full           = full_q;
   assign gate_open      = (state_q == OPEN);
   assign entry_rejected = rej_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl with 4 bays and a 3-cycle gate.
module tb_parking_lot_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       sense_entry;
   logic [3:0] sense_exit;
   logic [3:0] gled;
   logic [3:0] rled;
   logic [2:0] occ_count;
   logic       full;
   logic       gate_open;
   logic       entry_rejected;

   int vectors = 0;
   int miscompares = 0;

   parking_lot_ctrl #(
      .NUM_SLOTS(4),
      .GATE_OPEN_CYCLES(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sense_entry(sense_entry),
      .sense_exit(sense_exit),
      .gled(gled),
      .rled(rled),
      .occ_count(occ_count),
      .full(full),
      .gate_open(gate_open),
      .entry_rejected(entry_rejected)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sense_entry = 1'b0;
      sense_exit = 4'b0000;
      tick();
      tick();
      reset = 1'b0;
      vectors++;
      if ({gled, rled, occ_count, full, gate_open, entry_rejected}
          !== {4'b1111, 4'b0000, 3'd0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_state got g=%b r=%b c=%0d f=%b go=%b rj=%b req g=1111 r=0000 c=0 f=0 go=0 rj=0",
                  gled, rled, occ_count, full, gate_open, entry_rejected);
      end
   endtask

   task automatic test_fill();
      logic [3:0] exp_occ [4];
      exp_occ = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
      for (int k = 0; k < 4; k++) begin
         sense_entry = 1'b1;
         tick();
         sense_entry = 1'b0;
         vectors++;
         if ({rled, occ_count, full} !== {exp_occ[k], 3'(k + 1), (k == 3)}) begin
            miscompares++;
            $display("FAIL fill_%0d got r=%b c=%0d f=%b req r=%b c=%0d f=%b",
                     k, rled, occ_count, full, exp_occ[k], k + 1, (k == 3));
         end
         for (int c = 0; c < 4; c++) begin
            vectors++;
            if (gate_open !== (c < 3)) begin
               miscompares++;
               $display("FAIL gate_window_%0d_c%0d got %b req %b",
                        k, c, gate_open, (c < 3));
            end
            tick();
         end
      end
      sense_entry = 1'b1;
      tick();
      sense_entry = 1'b0;
      vectors++;
      if ({entry_rejected, rled, occ_count, gate_open} !== {1'b1, 4'b1111, 3'd4, 1'b0}) begin
         miscompares++;
         $display("FAIL fifth_reject got rj=%b r=%b c=%0d go=%b req rj=1 r=1111 c=4 go=0",
                  entry_rejected, rled, occ_count, gate_open);
      end
      tick();
      vectors++;
      if (entry_rejected !== 1'b0) begin
         miscompares++;
         $display("FAIL reject_pulse_width got %b req 0", entry_rejected);
      end
   endtask

   task automatic test_exit_realloc();
      sense_exit = 4'b0010;
      tick();
      sense_exit = 4'b0000;
      vectors++;
      if ({gled, occ_count, full} !== {4'b0010, 3'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL exit_bay1 got g=%b c=%0d f=%b req g=0010 c=3 f=0",
                  gled, occ_count, full);
      end
      sense_entry = 1'b1;
      tick();
      sense_entry = 1'b0;
      vectors++;
      if ({rled, occ_count, full} !== {4'b1111, 3'd4, 1'b1}) begin
         miscompares++;
         $display("FAIL realloc_bay1 got r=%b c=%0d f=%b req r=1111 c=4 f=1",
                  rled, occ_count, full);
      end
      repeat (4) tick();
   endtask

   task automatic test_simultaneous();
      sense_exit = 4'b0101;
      sense_entry = 1'b1;
      tick();
      sense_exit = 4'b0000;
      sense_entry = 1'b0;
      vectors++;
      if ({entry_rejected, rled, occ_count, full} !== {1'b1, 4'b1010, 3'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL sim_full_reject got rj=%b r=%b c=%0d f=%b req rj=1 r=1010 c=2 f=0",
                  entry_rejected, rled, occ_count, full);
      end
      tick();
      sense_exit = 4'b1010;
      tick();
      sense_exit = 4'b0000;
      vectors++;
      if ({rled, occ_count} !== {4'b0000, 3'd0}) begin
         miscompares++;
         $display("FAIL two_exits got r=%b c=%0d req r=0000 c=0", rled, occ_count);
      end
      tick();
      sense_entry = 1'b1;
      tick();
      sense_entry = 1'b0;
      repeat (4) tick();
      sense_entry = 1'b1;
      sense_exit = 4'b0001;
      tick();
      sense_entry = 1'b0;
      sense_exit = 4'b0000;
      vectors++;
      if ({rled, occ_count, entry_rejected} !== {4'b0010, 3'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL sim_entry_exit got r=%b c=%0d rj=%b req r=0010 c=1 rj=0",
                  rled, occ_count, entry_rejected);
      end
      repeat (4) tick();
   endtask

   task automatic test_gate_busy();
      sense_entry = 1'b1;
      tick();
      sense_entry = 1'b0;
      tick();
      sense_entry = 1'b1;
      tick();
      sense_entry = 1'b0;
      vectors++;
      if ({entry_rejected, rled, occ_count, gate_open} !== {1'b1, 4'b0011, 3'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL gate_busy got rj=%b r=%b c=%0d go=%b req rj=1 r=0011 c=2 go=1",
                  entry_rejected, rled, occ_count, gate_open);
      end
      repeat (4) tick();
   endtask

   task automatic test_level_hold();
      int rej_seen = 0;
      sense_entry = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (entry_rejected) rej_seen++;
      end
      sense_entry = 1'b0;
      vectors++;
      if ({rled, occ_count, gate_open} !== {4'b0111, 3'd3, 1'b0} || rej_seen != 0) begin
         miscompares++;
         $display("FAIL level_hold got r=%b c=%0d go=%b rej=%0d req r=0111 c=3 go=0 rej=0",
                  rled, occ_count, gate_open, rej_seen);
      end
      tick();
      sense_exit = 4'b1000;
      tick();
      sense_exit = 4'b0000;
      vectors++;
      if ({rled, occ_count, full, gate_open, entry_rejected}
          !== {4'b0111, 3'd3, 3'b000}) begin
         miscompares++;
         $display("FAIL ghost_exit got r=%b c=%0d f=%b go=%b rj=%b req r=0111 c=3 f=0 go=0 rj=0",
                  rled, occ_count, full, gate_open, entry_rejected);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      sense_exit = 4'b0100;
      tick();
      sense_exit = 4'b0000;
      tick();
      sense_entry = 1'b1;
      tick();
      sense_entry = 1'b0;
      vectors++;
      if ({rled, gate_open} !== {4'b0111, 1'b1}) begin
         miscompares++;
         $display("FAIL pre_reset_open got r=%b go=%b req r=0111 go=1", rled, gate_open);
      end
      sense_exit = 4'b0001;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({gled, rled, occ_count, full, gate_open, entry_rejected}
          !== {4'b1111, 4'b0000, 3'd0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_mid got g=%b r=%b c=%0d f=%b go=%b rj=%b req g=1111 r=0000 c=0 f=0 go=0 rj=0",
                  gled, rled, occ_count, full, gate_open, entry_rejected);
      end
      tick();
      vectors++;
      if ({gate_open, occ_count} !== {1'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL post_release got go=%b c=%0d req go=0 c=0", gate_open, occ_count);
      end
      sense_entry = 1'b1;
      tick();
      sense_entry = 1'b0;
      tick();
      vectors++;
      if ({rled, occ_count} !== {4'b0001, 3'd1}) begin
         miscompares++;
         $display("FAIL held_exit_no_event got r=%b c=%0d req r=0001 c=1", rled, occ_count);
      end
      sense_exit = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_exit_realloc();
      test_simultaneous();
      test_gate_busy();
      test_level_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
